// File: rtl/boot_loader_pkg.sv
// boot_loader shared definitions: FSM encodings and frame constants.
// Optional timeout is enabled with BOOT_LOADER_TIMEOUT_EN (see boot_loader.sv).
package boot_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// byte_packer: gathers bytes LSB-first into 32-bit words.
// word/word_valid are registered; word holds between pulses.
module byte_packer
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  data,
    input  logic        valid,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last
);

    logic [LANE_W-1:0] lane;
    logic [23:0]       shreg;

    assign last = (lane == LANE_W'(BYTES_PER_WORD - 1));

    // Shift lower lanes in; emit the word on the final lane.
    always_ff @(posedge clk) begin
        if (clear) begin
            lane       <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (valid) begin
                if (last) begin
                    word       <= {data, shreg};
                    word_valid <= 1'b1;
                    lane       <= '0;
                end else begin
                    shreg <= {data, shreg[23:8]};
                    lane  <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, checksummed image and writes
// it to instruction memory. Inter-byte timeout: BOOT_LOADER_TIMEOUT_EN.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wd,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t            state;
    state_t            state_nx;
    logic              armed;
    logic              hs;
    logic [7:0]        len_lo;
    logic [15:0]       n_words;
    logic [15:0]       n_hdr;
    logic [CSUM_W-1:0] csum;
    logic              pk_last;
    logic              last_word;
    logic              tmo_hit;

    assign hs        = rx_valid && rx_ready;
    assign n_hdr     = {rx_data, len_lo};
    assign last_word = pk_last && (words_loaded == n_words - 16'd1);

    byte_packer u_packer (
        .clk        (CLK),
        .clear      (rst),
        .data       (rx_data),
        .valid      (hs && (state == DATA)),
        .word       (im_wd),
        .word_valid (im_we),
        .last       (pk_last)
    );

`ifdef BOOT_LOADER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_run;

    assign tmo_run = (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign tmo_hit = tmo_run && !hs
                  && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, restarted by every accepted byte.
    always_ff @(posedge CLK) begin
        if (rst || hs || !tmo_run) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= LEN_LO;
        end else begin
            state <= state_nx;
        end
    end

    // Frame sequencing; a timeout overrides any pending move.
    always_comb begin
        state_nx = state;
        unique case (state)
            LEN_LO: if (hs) state_nx = LEN_HI;
            LEN_HI: begin
                if (hs) begin
                    if (n_hdr == 16'd0) begin
                        state_nx = CSUM;
                    end else if ({1'b0, n_hdr} > CAPACITY) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: if (hs && last_word) state_nx = CSUM;
            CSUM: begin
                if (hs) begin
                    state_nx = (rx_data == csum) ? DONE : ERR;
                end
            end
            DONE:    state_nx = DONE;
            ERR:     state_nx = ERR;
            default: state_nx = LEN_LO;
        endcase
        if (tmo_hit) state_nx = ERR;
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        rx_ready  = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        unique case (state)
            LEN_LO, LEN_HI, DATA, CSUM: rx_ready = armed;
            DONE:    load_done = 1'b1;
            ERR:     load_err  = 1'b1;
            default: rx_ready  = 1'b0;
        endcase
    end

    // Header capture, checksum, word address/count and core reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            armed        <= 1'b0;
            len_lo       <= '0;
            n_words      <= '0;
            csum         <= '0;
            im_addr      <= '0;
            words_loaded <= '0;
            core_rst     <= 1'b1;
        end else begin
            armed    <= 1'b1;
            core_rst <= (state != DONE);
            if (hs && (state == LEN_LO)) begin
                len_lo <= rx_data;
            end
            if (hs && (state == LEN_HI)) begin
                n_words <= n_hdr;
            end
            if (hs && (state == DATA)) begin
                csum <= csum + rx_data;
                if (pk_last) begin
                    im_addr      <= words_loaded[ADDR_WIDTH-1:0];
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames against boot_loader.
// Expected words, addresses and checksums are computed here.
module tb_boot_loader;

    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wd;
    logic          core_rst;
    logic          load_done;
    logic          load_err;
    logic [15:0]   words_loaded;

    boot_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wd        (im_wd),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    // Log every memory write seen mid-cycle.
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_wd);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wd_at(input int i);
        if (i < wd_q.size()) return wd_q[i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] wa_at(input int i);
        if (i < wa_q.size()) return 32'(wa_q[i]);
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [7:0] pbyte(input int k, input int i);
        return 8'((k * 4 + i) * 37 + 11);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && w < 20) begin
            @(posedge CLK);
            #1;
            w++;
        end
        if (rx_ready !== 1'b1) chk("ready_wait", 32'(rx_ready), 32'd1);
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic send_frame1(input logic [7:0] cs);
        logic [7:0] f [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                               8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 10; i++) send_byte(f[i]);
        send_byte(cs);
    endtask

    task automatic check_frame1_writes(input string p);
        chk({p, "_nwr"}, 32'(wd_q.size()), 32'd2);
        chk({p, "_a0"}, wa_at(0), 32'd0);
        chk({p, "_d0"}, wd_at(0), 32'h0000_0013);
        chk({p, "_a1"}, wa_at(1), 32'd1);
        chk({p, "_d1"}, wd_at(1), 32'h0010_0093);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sum;
        logic [31:0] expw;
        int          c0;
        int          bad;

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_wd", im_wd, 32'd0);
        chk("rst_core", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("rdy_first", 32'(rx_ready), 32'd0);
        @(posedge CLK);
        #1;
        chk("rdy_next", 32'(rx_ready), 32'd1);

        // Two-word frame, payload sum 0x13+0x93+0x10 = 0xB6
        send_frame1(8'hB6);
        chk("f1_done", 32'(load_done), 32'd1);
        chk("f1_core_hold", 32'(core_rst), 32'd1);
        @(posedge CLK);
        #1;
        chk("f1_core_fall", 32'(core_rst), 32'd0);
        chk("f1_words", 32'(words_loaded), 32'd2);
        chk("f1_ready", 32'(rx_ready), 32'd0);
        chk("f1_err", 32'(load_err), 32'd0);
        chk("f1_addr_hold", 32'(im_addr), 32'd1);
        chk("f1_wd_hold", im_wd, 32'h0010_0093);
        check_frame1_writes("f1");

        // Same frame, wrong checksum
        do_reset(1);
        send_frame1(8'hB7);
        repeat (2) @(posedge CLK);
        #1;
        chk("f2_err", 32'(load_err), 32'd1);
        chk("f2_done", 32'(load_done), 32'd0);
        chk("f2_core", 32'(core_rst), 32'd1);
        chk("f2_ready", 32'(rx_ready), 32'd0);
        chk("f2_nwr", 32'(wd_q.size()), 32'd2);

        // Empty image
        do_reset(1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(posedge CLK);
        #1;
        chk("f3_done", 32'(load_done), 32'd1);
        chk("f3_core", 32'(core_rst), 32'd0);
        chk("f3_nwr", 32'(wd_q.size()), 32'd0);
        chk("f3_words", 32'(words_loaded), 32'd0);

        // N = 257 exceeds capacity
        do_reset(1);
        send_byte(8'h01);
        send_byte(8'h01);
        chk("f4_err", 32'(load_err), 32'd1);
        chk("f4_ready", 32'(rx_ready), 32'd0);
        repeat (6) @(posedge CLK);
        #1;
        chk("f4_nwr", 32'(wd_q.size()), 32'd0);
        chk("f4_core", 32'(core_rst), 32'd1);

        // N = 256, back-to-back bytes
        do_reset(1);
        send_byte(8'h00);
        send_byte(8'h01);
        sum = 8'h00;
        c0  = cyc;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 4; i++) begin
                sum = sum + pbyte(k, i);
                send_byte(pbyte(k, i));
            end
        end
        chk("f5_b2b_cycles", 32'(cyc - c0), 32'd1024);
        send_byte(sum);
        chk("f5_done", 32'(load_done), 32'd1);
        @(posedge CLK);
        #1;
        chk("f5_nwr", 32'(wd_q.size()), 32'd256);
        chk("f5_last_addr", wa_at(255), 32'd255);
        chk("f5_words", 32'(words_loaded), 32'd256);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            expw = {pbyte(k, 3), pbyte(k, 2), pbyte(k, 1), pbyte(k, 0)};
            if (wd_at(k) !== expw || wa_at(k) !== 32'(k)) bad++;
        end
        chk("f5_bad_words", 32'(bad), 32'd0);

        // Reset after two payload bytes, byte offered during reset
        do_reset(1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        do_reset(1);
        rx_valid = 1'b0;
        chk("f6_words_clr", 32'(words_loaded), 32'd0);
        chk("f6_core", 32'(core_rst), 32'd1);
        send_frame1(8'hB6);
        chk("f6_done", 32'(load_done), 32'd1);
        check_frame1_writes("f6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
